// File: rtl/cu_pipe.sv
// Pipelined RV32I control unit: decodes the ID-stage instruction into a control
// bundle, carries it through EX/MEM/WB, stalls on load-use and bubbles on flush.
module cu_pipe #(
   parameter int unsigned REG_AW          = 5,
   parameter bit          ENABLE_M        = 1'b0,
   parameter int unsigned RESET_PC_BUBBLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd,
   input  logic              flush,
   output logic              stall,
   output logic [3:0]        ex_alu_op,
   output logic              ex_alu_src_imm,
   output logic [2:0]        ex_imm_type,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic              ex_illegal,
   output logic              mem_we,
   output logic              mem_re,
   output logic [2:0]        mem_size,
   output logic              wb_reg_we,
   output logic [1:0]        wb_sel,
   output logic [REG_AW-1:0] wb_rd
);

   typedef enum logic [6:0] {
      OP_R      = 7'b0110011,
      OP_IMM    = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10,
      ALU_MUL   = 4'd11
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_type_e;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [6:0] F7_STD = 7'b0000000;
   localparam logic [6:0] F7_ALT = 7'b0100000;
   localparam logic [6:0] F7_MUL = 7'b0000001;

   localparam logic [1:0] BUBBLE_INIT = 2'(RESET_PC_BUBBLE);

   // Each stage keeps only the fields still consumed downstream.
   typedef struct packed {
      logic              reg_we;
      logic [1:0]        sel;
      logic [REG_AW-1:0] rd;
   } wb_ctrl_t;

   typedef struct packed {
      logic     we;
      logic     re;
      logic [2:0] size;
      wb_ctrl_t wb;
   } mem_ctrl_t;

   typedef struct packed {
      alu_op_e   alu_op;
      logic      alu_src_imm;
      imm_type_e imm_type;
      logic      branch;
      logic      jump;
      logic      illegal;
      mem_ctrl_t mem;
   } ex_ctrl_t;

   function automatic alu_op_e base_op(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   ex_ctrl_t  dec;
   logic      legal;
   logic      use_rs1;
   logic      use_rs2;
   ex_ctrl_t  ex_q;
   mem_ctrl_t mem_q;
   wb_ctrl_t  wb_q;
   logic [1:0] bubble_cnt;
   logic      hazard;
   logic      insert_bubble;

   // ---------------------------------------------------------------- decode
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; a missing default in always_comb infers a latch.
   always_comb begin
      dec     = '0;
      legal   = 1'b1;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OP_R: begin
            use_rs1          = 1'b1;
            use_rs2          = 1'b1;
            dec.mem.wb.reg_we = 1'b1;
            if (funct7 == F7_STD)                          dec.alu_op = base_op(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b000) dec.alu_op = ALU_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_op = ALU_SRA;
            else if (ENABLE_M && funct7 == F7_MUL && funct3 == 3'b000)
               dec.alu_op = ALU_MUL;
            else
               legal = 1'b0;
         end
         OP_IMM: begin
            use_rs1           = 1'b1;
            dec.alu_src_imm   = 1'b1;
            dec.imm_type      = IMM_I;
            dec.mem.wb.reg_we = 1'b1;
            dec.alu_op        = base_op(funct3);
            // Shift immediates reuse funct7 as the shift kind; anything else is undefined.
            if (funct3 == 3'b001) begin
               legal = (funct7 == F7_STD);
            end else if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT)      dec.alu_op = ALU_SRA;
               else if (funct7 != F7_STD) legal = 1'b0;
            end
         end
         OP_LOAD: begin
            use_rs1           = 1'b1;
            legal             = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            dec.alu_op        = ALU_ADD;
            dec.alu_src_imm   = 1'b1;
            dec.imm_type      = IMM_I;
            dec.mem.re        = 1'b1;
            dec.mem.size      = funct3;
            dec.mem.wb.reg_we = 1'b1;
            dec.mem.wb.sel    = WB_MEM;
         end
         OP_STORE: begin
            use_rs1         = 1'b1;
            use_rs2         = 1'b1;
            legal           = (funct3 <= 3'b010);
            dec.alu_op      = ALU_ADD;
            dec.alu_src_imm = 1'b1;
            dec.imm_type    = IMM_S;
            dec.mem.we      = 1'b1;
            dec.mem.size    = funct3;
         end
         OP_BRANCH: begin
            use_rs1      = 1'b1;
            use_rs2      = 1'b1;
            legal        = !(funct3 inside {3'b010, 3'b011});
            dec.alu_op   = ALU_SUB;
            dec.imm_type = IMM_B;
            dec.branch   = 1'b1;
         end
         OP_JAL: begin
            dec.alu_op        = ALU_ADD;
            dec.imm_type      = IMM_J;
            dec.jump          = 1'b1;
            dec.mem.wb.reg_we = 1'b1;
            dec.mem.wb.sel    = WB_PC4;
         end
         OP_JALR: begin
            use_rs1           = 1'b1;
            legal             = (funct3 == 3'b000);
            dec.alu_op        = ALU_ADD;
            dec.alu_src_imm   = 1'b1;
            dec.imm_type      = IMM_I;
            dec.jump          = 1'b1;
            dec.mem.wb.reg_we = 1'b1;
            dec.mem.wb.sel    = WB_PC4;
         end
         OP_LUI: begin
            dec.alu_op        = ALU_PASSB;
            dec.alu_src_imm   = 1'b1;
            dec.imm_type      = IMM_U;
            dec.mem.wb.reg_we = 1'b1;
         end
         OP_AUIPC: begin
            dec.alu_op        = ALU_ADD;
            dec.alu_src_imm   = 1'b1;
            dec.imm_type      = IMM_U;
            dec.mem.wb.reg_we = 1'b1;
         end
         default: legal = 1'b0;
      endcase

      dec.mem.wb.rd = rd;
      if (!legal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
      if (rd == '0) dec.mem.wb.reg_we = 1'b0;
   end

   // ---------------------------------------------------------------- hazards
   assign hazard = id_valid && ex_q.mem.re && ex_q.mem.wb.reg_we &&
                   ((use_rs1 && ex_q.mem.wb.rd == rs1) ||
                    (use_rs2 && ex_q.mem.wb.rd == rs2));

   // Flush discards the ID instruction anyway, so it suppresses the stall.
   assign stall = rst_n && hazard && !flush;

   assign insert_bubble = flush || stall || !id_valid || (bubble_cnt != 2'd0);

   // ---------------------------------------------------------------- pipeline
   // NOTE: state registers use non-blocking assignments so every stage samples
   // the previous stage's value from before this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
         bubble_cnt <= BUBBLE_INIT;
      end else begin
         ex_q  <= insert_bubble ? '0 : dec;
         mem_q <= ex_q.mem;
         wb_q  <= mem_q.wb;
         if (bubble_cnt != 2'd0) bubble_cnt <= bubble_cnt - 2'd1;
      end
   end

   assign ex_alu_op      = ex_q.alu_op;
   assign ex_alu_src_imm = ex_q.alu_src_imm;
   assign ex_imm_type    = ex_q.imm_type;
   assign ex_branch      = ex_q.branch;
   assign ex_jump        = ex_q.jump;
   assign ex_illegal     = ex_q.illegal;
   assign mem_we         = mem_q.we;
   assign mem_re         = mem_q.re;
   assign mem_size       = mem_q.size;
   assign wb_reg_we      = wb_q.reg_we;
   assign wb_sel         = wb_q.sel;
   assign wb_rd          = wb_q.rd;

endmodule
